// File: rtl/pes_elevator_pkg.sv
// pes_elevator_pkg: shared scheduler state encoding, floor sizing defaults and floor index type.
package pes_elevator_pkg;
  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W = 3;
  typedef logic [FLOOR_W-1:0] floor_t;
  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, CLEAR} state_t;
endpackage

// File: rtl/pes_call_debounce.sv
// pes_call_debounce: per-bit 2-flop synchronizer followed by a stable-sample counter filter.
module pes_call_debounce #(
  parameter int WIDTH = 8,
  parameter int CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [WIDTH-1:0] s1, s2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic q;
    // the level flips only after CYCLES consecutive samples disagree with it
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        q <= 1'b0;
      end else if (s2[i] == q) cnt <= '0;
      else if (cnt == CW'(CYCLES - 1)) begin
        cnt <= '0;
        q <= s2[i];
      end else cnt <= cnt + CW'(1);
    assign dout[i] = q;
  end
endmodule

// File: rtl/pes_elevator_call_sched.sv
// pes_elevator_call_sched: latches floor calls and dispatches SCAN-ordered targets to the core.
// Optional PES_CALL_DEBOUNCE_EN filters call buttons through pes_call_debounce before edge detection.
module pes_elevator_call_sched
  import pes_elevator_pkg::*;
#(
  parameter int NUM_FLOORS = pes_elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W = pes_elevator_pkg::FLOOR_W,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  complete,
  input  logic                  over_weight,
  output logic                  req_valid,
  output logic [FLOOR_W-1:0]    request_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);
  state_t state;
  logic [NUM_FLOORS-1:0] btn_f, btn_prev, rise, clr_mask, pend_nxt;
  logic [FLOOR_W-1:0] cf, up_idx, dn_idx, target;
  logic up_f, dn_f, here;
`ifdef PES_CALL_DEBOUNCE_EN
  pes_call_debounce #(.WIDTH(NUM_FLOORS), .CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk), .rst_n(reset), .din(call_btn), .dout(btn_f)
  );
`else
  assign btn_f = call_btn;
`endif
  if (DEBOUNCE_CYCLES < 1 || NUM_FLOORS > (1 << FLOOR_W)) begin : g_bad_params
    $error("pes_elevator_call_sched: inconsistent parameters");
  end
  // a call landing on the floor being cleared is dropped: the car is already there
  assign rise = btn_f & ~btn_prev;
  assign clr_mask = (state == CLEAR) ? NUM_FLOORS'(1) << request_floor : '0;
  assign pend_nxt = (pending | rise) & ~clr_mask;
  assign cf = (int'(cur_floor) >= NUM_FLOORS) ? FLOOR_W'(NUM_FLOORS - 1) : cur_floor;
  assign here = pending[cf];
  always_comb begin
    up_f = 1'b0;
    dn_f = 1'b0;
    up_idx = '0;
    dn_idx = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && i > int'(cf)) begin
        up_f = 1'b1;
        up_idx = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && i < int'(cf)) begin
        dn_f = 1'b1;
        dn_idx = FLOOR_W'(i);
      end
  end
  assign target = here ? cf : dir_up ? (up_f ? up_idx : dn_idx) : (dn_f ? dn_idx : up_idx);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pending <= '0;
      btn_prev <= '0;
      req_valid <= 1'b0;
      request_floor <= '0;
      dir_up <= 1'b1;
    end else begin
      btn_prev <= btn_f;
      pending <= pend_nxt;
      case (state)
        IDLE: if (pending != '0 && !over_weight) state <= SELECT;
        SELECT:
          if (pending == '0 || over_weight) state <= IDLE;
          else begin
            request_floor <= target;
            req_valid <= 1'b1;
            dir_up <= here ? dir_up : dir_up ? up_f : !dn_f;
            state <= ISSUE;
          end
        ISSUE:
          if (complete) begin
            req_valid <= 1'b0;
            state <= CLEAR;
          end
        CLEAR: state <= (pend_nxt != '0) ? SELECT : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pes_elevator_call_sched.sv
// tb_pes_elevator_call_sched: vector table plus request scoreboard for the call scheduler.
module tb_pes_elevator_call_sched;
  typedef struct {
    int cur;
    int btn;
    logic [2:0] fl;
    logic dir;
  } vec_t;
  typedef struct {
    logic [2:0] fl;
    logic dir;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] call_btn = '0;
  logic [2:0] cur_floor = '0;
  logic complete = 1'b0;
  logic over_weight = 1'b0;
  logic req_valid, dir_up, busy;
  logic [2:0] request_floor;
  logic [7:0] pending;
  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic rv_q = 1'b0;
  vec_t vt[8];
  logic [2:0] scan_fl[3];

  pes_elevator_call_sched dut (
    .clk(clk), .reset(reset), .call_btn(call_btn), .cur_floor(cur_floor),
    .complete(complete), .over_weight(over_weight), .req_valid(req_valid),
    .request_floor(request_floor), .pending(pending), .dir_up(dir_up), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (req_valid !== 1'b1 && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, 32'(req_valid), 1);
  endtask

  task automatic pulse_complete();
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
  endtask

  // each new request is popped from the scoreboard the moment req_valid rises
  always @(negedge clk) begin
    if (req_valid && !rv_q) begin
      if (sb.size() == 0) chk("unexpected_req", 32'(request_floor), 32'hFFFF);
      else begin
        mon_e = sb.pop_front();
        chk("req_floor", 32'(request_floor), 32'(mon_e.fl));
        chk("req_dir", 32'(dir_up), 32'(mon_e.dir));
      end
    end
    rv_q = req_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 5, 3'd5, 1'b1};
    vt[1] = '{6, 2, 3'd2, 1'b0};
    vt[2] = '{4, 1, 3'd1, 1'b0};
    vt[3] = '{7, 0, 3'd0, 1'b0};
    vt[4] = '{0, 0, 3'd0, 1'b0};
    vt[5] = '{3, 3, 3'd3, 1'b0};
    vt[6] = '{1, 7, 3'd7, 1'b1};
    vt[7] = '{5, 5, 3'd5, 1'b1};
    scan_fl = '{3'd4, 3'd6, 3'd1};
    repeat (2) @(negedge clk);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_request_floor", 32'(request_floor), 0);
    chk("rst_dir_up", 32'(dir_up), 1);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      cur_floor = 3'(vt[v].cur);
      sb.push_back('{vt[v].fl, vt[v].dir});
      call_btn[vt[v].btn] = 1'b1;
      @(negedge clk);
      call_btn = '0;
      chk($sformatf("v%0d_pending", v), 32'(pending), 32'(1) << vt[v].btn);
      chk($sformatf("v%0d_lat1", v), 32'(req_valid), 0);
      @(negedge clk);
      chk($sformatf("v%0d_lat2", v), 32'(req_valid), 0);
      @(negedge clk);
      chk($sformatf("v%0d_lat3", v), 32'(req_valid), 1);
      pulse_complete();
      chk($sformatf("v%0d_drop", v), 32'(req_valid), 0);
      chk($sformatf("v%0d_busy_clear", v), 32'(busy), 1);
      @(negedge clk);
      chk($sformatf("v%0d_cleared", v), 32'(pending), 0);
      chk($sformatf("v%0d_idle", v), 32'(busy), 0);
    end
    // SCAN order from floor 3 going up with calls at 1, 6 and 4
    @(negedge clk);
    cur_floor = 3'd3;
    sb.push_back('{3'd4, 1'b1});
    sb.push_back('{3'd6, 1'b1});
    sb.push_back('{3'd1, 1'b0});
    call_btn = 8'h52;
    @(negedge clk);
    call_btn = '0;
    chk("scan_pending", 32'(pending), 32'h52);
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("scan%0d", k));
      cur_floor = scan_fl[k];
      pulse_complete();
      chk($sformatf("scan%0d_clear_gap", k), 32'(req_valid), 0);
      @(negedge clk);
      if (k < 2) begin
        chk($sformatf("scan%0d_select_gap", k), 32'(req_valid), 0);
        chk($sformatf("scan%0d_select_busy", k), 32'(busy), 1);
      end else begin
        chk("scan_done_pending", 32'(pending), 0);
        chk("scan_done_busy", 32'(busy), 0);
      end
    end
    // clear-versus-set collision while clearing floor 4
    @(negedge clk);
    cur_floor = 3'd0;
    sb.push_back('{3'd4, 1'b1});
    call_btn[4] = 1'b1;
    @(negedge clk);
    call_btn = '0;
    wait_req("coll_first");
    cur_floor = 3'd4;
    pulse_complete();
    sb.push_back('{3'd7, 1'b1});
    call_btn = 8'h90;
    @(negedge clk);
    call_btn = '0;
    chk("coll_pending", 32'(pending), 32'h80);
    wait_req("coll_second");
    cur_floor = 3'd7;
    pulse_complete();
    @(negedge clk);
    chk("coll_done_pending", 32'(pending), 0);
    // over_weight holds off dispatch until released
    @(negedge clk);
    over_weight = 1'b1;
    cur_floor = 3'd5;
    call_btn[3] = 1'b1;
    @(negedge clk);
    call_btn = '0;
    chk("ow_pending", 32'(pending), 32'h08);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ow_hold%0d", k), 32'({req_valid, busy}), 0);
    end
    sb.push_back('{3'd3, 1'b0});
    over_weight = 1'b0;
    @(negedge clk);
    chk("ow_select", 32'(req_valid), 0);
    @(negedge clk);
    chk("ow_issue", 32'(req_valid), 1);
    chk("ow_floor", 32'(request_floor), 3);
    // asynchronous reset in the middle of ISSUE
    call_btn[6] = 1'b1;
    @(negedge clk);
    call_btn = '0;
    chk("mid_pending", 32'(pending), 32'h48);
    chk("mid_dir", 32'(dir_up), 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_req_valid", 32'(req_valid), 0);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_dir_up", 32'(dir_up), 1);
    chk("arst_request_floor", 32'(request_floor), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d", k), 32'({req_valid, busy, pending}), 0);
    end
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pes_elevator_call_sched.md
Name: pes_elevator_call_sched

Overview:
- Upstream stage of the elevator controller core.
- Latches floor-call buttons into a pending-call register and selects the next target floor using a SCAN/collective policy (keep serving in the current travel direction, then reverse).
- Drives the core's request_floor with a valid/complete handshake.
- Exports pending-call lamps and the travel direction to the IO wrapper.

Parameters:
- NUM_FLOORS, 8, number of floors and call buttons.
- FLOOR_W, 3, floor index width; ceil(log2(NUM_FLOORS)).
- DEBOUNCE_CYCLES, 16, stable cycles required per button; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; all state clears when low.
- call_btn  input  NUM_FLOORS  raw call buttons, one per floor, level, active-high.
- cur_floor  input  FLOOR_W  current car floor, from core out_current_floor.
- complete  input  1  core pulse: car reached request_floor and service finished.
- over_weight  input  1  core flag; inhibits new dispatch while high.
- req_valid  output  1  request_floor is valid and committed to the core.
- request_floor  output  FLOOR_W  target floor to the core.
- pending  output  NUM_FLOORS  latched calls (lamp drive).
- dir_up  output  1  1 = scanning up, 0 = scanning down.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (reset low): pending=0, req_valid=0, request_floor=0, dir_up=1, busy=0, FSM=IDLE, button edge registers=0.
- Call capture:
  - A rising edge on call_btn[i] (registered previous value vs current) sets pending[i] on the next clock.
  - A held button does not re-set the bit after it has been cleared.
- FSM: IDLE, SELECT, ISSUE, CLEAR.
- IDLE:
  - Go to SELECT when pending!=0 and over_weight=0.
  - Otherwise stay.
- SELECT (1 cycle): compute the target combinationally from pending, cur_floor and dir_up.
  - If pending[cur_floor]: target=cur_floor.
  - Else if dir_up: lowest pending index > cur_floor. If none, highest pending index < cur_floor, and set dir_up=0.
  - Else (down): highest pending index < cur_floor. If none, lowest pending index > cur_floor, and set dir_up=1.
  - Register request_floor=target and set req_valid=1; go to ISSUE.
  - If pending became 0 or over_weight=1, return to IDLE without asserting req_valid.
- ISSUE:
  - Hold req_valid=1 and request_floor stable until complete=1.
  - No retargeting: new calls only set pending bits.
  - On complete, drop req_valid the next cycle and go to CLEAR.
  - complete while not in ISSUE is ignored.
- CLEAR (1 cycle):
  - Clear pending[request_floor].
  - If a new edge for the same floor arrives this cycle, clear wins; the car is already at that floor.
  - Edges for other floors set normally.
  - Go to SELECT if the remaining pending!=0, else IDLE.
- Latency: button edge to req_valid is 3 cycles from IDLE (capture, IDLE->SELECT, SELECT->ISSUE).
- Request spacing: minimum of 2 cycles with req_valid low between consecutive requests (CLEAR, SELECT).
- Limits:
  - cur_floor >= NUM_FLOORS is treated as NUM_FLOORS-1.
  - Button bits for index >= NUM_FLOORS do not exist.
- Reset asserted mid-ISSUE: req_valid drops immediately (asynchronous) and all pending calls are lost.
- busy=1 in SELECT, ISSUE and CLEAR.

Optional Feature:
- Macro: PES_CALL_DEBOUNCE_EN.
- Defined:
  - Each call_btn passes through a 2-flop synchronizer, then a per-floor counter.
  - The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - Edge detection runs on the filtered level.
  - Added latency = 2 + DEBOUNCE_CYCLES cycles.
- Undefined: no synchronizer and no counters; edge detection is applied directly to call_btn.

Decomposition:
- Shared package pes_elevator_pkg: FSM state enum (IDLE/SELECT/ISSUE/CLEAR), the FLOOR_W and NUM_FLOORS defaults, and the floor index typedef.
- One natural sub-module: pes_call_debounce (synchronizer + counter per bit). It is instantiated only under PES_CALL_DEBOUNCE_EN.

Test Plan:
- Single call: cur_floor=0, pulse call_btn[5] -> pending=0x20; req_valid=1 with request_floor=5 at 3 cycles; complete pulse -> pending=0, req_valid=0, returns to IDLE.
- SCAN order: cur_floor=3, dir_up=1, pending floors {1,6,4} -> requests issued 4, 6, then 1 with dir_up=0 (cur_floor updated to each target before complete).
- Current-floor call: cur_floor=2, press call_btn[2] -> request_floor=2 issued; dir_up unchanged.
- Clear vs set collision: in CLEAR for floor 4, call_btn[4] and call_btn[7] rising in the same cycle -> pending[4]=0, pending[7]=1.
- over_weight=1 with pending=0x08 -> req_valid stays 0; deasserting over_weight -> request_floor=3 issued within 2 cycles.
- Reset mid-ISSUE: drive reset low while req_valid=1 -> req_valid, pending, busy=0 immediately; dir_up=1.
